// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART blocks.
// UART_RX_BREAK_DET_EN adds the BRK receiver state.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } par_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
`ifdef UART_RX_BREAK_DET_EN
        , BRK
`endif
    } rx_state_e;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
    } rx_user_t;

    function automatic int calc_div(input longint clkf,
                                    input longint baud,
                                    input longint ovs);
        return int'(clkf / (baud * ovs));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks while enabled.
// Counter is held at zero while disabled so each enable starts a fresh period.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    if (DIV < 1) begin : g_div_chk
        $error("uart_baud_tick: DIV must be >= 1");
    end

    always_ff @(posedge clk) begin
        if (!rstn || !i_en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign o_tick = i_en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote, parity/stop config, AXI-S out.
// Define UART_RX_BREAK_DET_EN to turn all-zero frames into o_break pulses.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKF        = 100000000,
    parameter int BAUD        = 921600,
    parameter int DLEN        = 8,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_rxs,
    input  logic [1:0]      i_par_mode,
    input  logic            i_stop2,
    output logic            o_tvalid,
    input  logic            i_tready,
    output logic [DLEN-1:0] o_tdata,
    output logic [1:0]      o_tuser,
    output logic            o_overrun,
    input  logic            i_clr_overrun,
    output logic            o_break,
    output logic            o_busy
);

    localparam int DIV = calc_div(CLKF, BAUD, OVS);
    localparam int SW  = $clog2(OVS);
    localparam int BW  = $clog2(DLEN + 1);

    localparam logic [SW-1:0] S_LO  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVS / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DLEN - 1);

    if (DIV < 1) begin : g_div_chk
        $error("uart_rx_os: CLKF/(BAUD*OVS) must be >= 1");
    end
    if (DLEN < 5 || DLEN > 9) begin : g_dlen_chk
        $error("uart_rx_os: DLEN must be 5..9");
    end
    if (OVS < 8 || (OVS % 2) != 0) begin : g_ovs_chk
        $error("uart_rx_os: OVS must be even and >= 8");
    end
    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("uart_rx_os: SYNC_STAGES must be >= 2");
    end

    rx_state_e state;
    rx_state_e state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd;
    logic                   tick;
    logic [SW-1:0]          scnt;
    logic                   samp_a;
    logic                   samp_b;
    logic                   maj;
    logic                   mid;
    logic [BW-1:0]          bcnt;
    logic [DLEN-1:0]        shreg;
    par_mode_e              cfg_par;
    logic                   cfg_stop2;
    logic                   par_err_q;
    logic                   frame_err_q;
    logic                   par_exp;
    logic                   done;
    logic                   deliver;
    logic                   ovr_set;
    rx_user_t               user_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_rxs};
        end
    end

    assign rxd = sync_q[SYNC_STAGES-1];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (state != IDLE),
        .o_tick (tick)
    );

    // Third vote is the live line at the resolving tick.
    assign maj = (samp_a & samp_b) | (samp_a & rxd) | (samp_b & rxd);
    assign mid = tick && (scnt == S_HI);
    assign par_exp = (cfg_par == PAR_ODD) ? ~(^shreg) : (^shreg);
    assign o_busy = (state != IDLE);

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit_q;
    logic stop1_q;
    logic stop1_now;
    logic brk_hit;

    assign stop1_now = (state == STOP1) ? maj : stop1_q;
    assign brk_hit = (shreg == '0)
                  && (cfg_par == PAR_NONE || !par_bit_q)
                  && !stop1_now;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxd) state_nxt = START;
            end
            START: begin
                if (mid) state_nxt = maj ? IDLE : DATA;
            end
            DATA: begin
                if (mid && bcnt == B_LAST) begin
                    state_nxt = (cfg_par != PAR_NONE) ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (mid) state_nxt = STOP1;
            end
            STOP1: begin
                if (mid) begin
                    if (cfg_stop2) begin
                        state_nxt = STOP2;
                    end else begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (mid) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            BRK: begin
                if (rxd) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
`ifdef UART_RX_BREAK_DET_EN
        if (done && brk_hit) state_nxt = BRK;
        deliver = done && !brk_hit;
`else
        deliver = done;
`endif
        ovr_set = deliver && o_tvalid && !i_tready;
        user_nxt.parity_err = par_err_q;
        user_nxt.frame_err  = frame_err_q | ~maj;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            scnt        <= '0;
            samp_a      <= 1'b1;
            samp_b      <= 1'b1;
            bcnt        <= '0;
            shreg       <= '0;
            cfg_par     <= PAR_NONE;
            cfg_stop2   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q   <= 1'b0;
            stop1_q     <= 1'b1;
`endif
        end else if (state == IDLE) begin
            scnt <= '0;
            bcnt <= '0;
            if (!rxd) begin
                cfg_par     <= (i_par_mode == 2'b11) ? PAR_NONE
                                                     : par_mode_e'(i_par_mode);
                cfg_stop2   <= i_stop2;
                par_err_q   <= 1'b0;
                frame_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                par_bit_q   <= 1'b0;
                stop1_q     <= 1'b1;
`endif
            end
        end else if (tick) begin
            scnt <= (scnt == S_END) ? '0 : scnt + SW'(1);
            if (scnt == S_LO) samp_a <= rxd;
            if (scnt == S_MID) samp_b <= rxd;
            if (scnt == S_HI) begin
                if (state == DATA) begin
                    shreg <= {maj, shreg[DLEN-1:1]};
                    bcnt  <= bcnt + BW'(1);
                end
                if (state == PARITY) begin
                    par_err_q <= maj ^ par_exp;
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_q <= maj;
`endif
                end
                if (state == STOP1) begin
                    frame_err_q <= frame_err_q | ~maj;
`ifdef UART_RX_BREAK_DET_EN
                    stop1_q     <= maj;
`endif
                end
            end
        end
    end

    // Output register: a held word is never overwritten without a handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_tvalid  <= 1'b0;
            o_tdata   <= '0;
            o_tuser   <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (o_tvalid && i_tready) o_tvalid <= 1'b0;
            if (deliver && (!o_tvalid || i_tready)) begin
                o_tvalid <= 1'b1;
                o_tdata  <= shreg;
                o_tuser  <= user_nxt;
            end
            if (i_clr_overrun) o_overrun <= 1'b0;
            if (ovr_set) o_overrun <= 1'b1;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_break <= 1'b0;
        end else begin
            o_break <= done && brk_hit;
        end
    end
`else
    assign o_break = 1'b0;
`endif

endmodule
